// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel edge detector: derived widths, latency and
// output-mode encodings.
package sobel_pkg;

    localparam int unsigned SOBEL_LAT = 4;

    typedef enum logic {
        MODE_BIN = 1'b0,
        MODE_MAG = 1'b1
    } mode_e;

    // Sideband flags that travel alongside each pixel through the pipeline.
    typedef struct packed {
        logic vld;
        logic sop;
        logic eop;
    } side_t;

    function automatic int unsigned abs_w(input int unsigned data_w);
        return data_w + 2;
    endfunction

    function automatic int unsigned sum_w(input int unsigned data_w);
        return data_w + 3;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two cascaded line delays addressed by column; taps return the pixel at the
// same column one and two lines earlier.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 640
) (
    input  logic                       clk,
    input  logic                       wr_en_i,
    input  logic [cnt_w(IMG_W)-1:0]    x_i,
    input  logic [DATA_W-1:0]          din_i,
    output logic [DATA_W-1:0]          row1_c_o,
    output logic [DATA_W-1:0]          row2_c_o
);

    logic [DATA_W-1:0] line1_mem [IMG_W];
    logic [DATA_W-1:0] line2_mem [IMG_W];

    assign row1_c_o = line1_mem[x_i];
    assign row2_c_o = line2_mem[x_i];

    // Read-before-write: the older line moves down as the new pixel lands.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            line1_mem[x_i] <= din_i;
            line2_mem[x_i] <= line1_mem[x_i];
        end
    end

endmodule

// File: rtl/sobel_gray.sv
// Streaming 3x3 Sobel edge detector on grayscale pixels with a fixed 4-cycle
// latency. Define SOBEL_BORDER_ZERO_EN to zero outputs of incomplete windows.
module sobel_gray
    import sobel_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 640
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic              din_vld,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W+2:0] thr,
    input  logic              mode,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic              dout_vld,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned ABS_W   = abs_w(DATA_W);
    localparam int unsigned SUM_W   = sum_w(DATA_W);
    localparam int unsigned G_W     = SUM_W;
    localparam int unsigned X_W     = cnt_w(IMG_W);
    localparam int unsigned Y_W     = 16;
    localparam int unsigned PIX_MAX = (2 ** DATA_W) - 1;

    // ---------------- position counters ----------------
    logic [X_W-1:0] x_q, x_d, px_c;
    logic [Y_W-1:0] y_q, y_d, py_c;

    always_comb begin
        px_c = din_sop ? '0 : x_q;
        py_c = din_sop ? '0 : y_q;
        x_d  = x_q;
        y_d  = y_q;
        if (din_vld) begin
            if (px_c == X_W'(IMG_W - 1)) begin
                x_d = '0;
                // Saturate so very tall frames never fall back into the border.
                y_d = (py_c == '1) ? py_c : py_c + Y_W'(1);
            end else begin
                x_d = px_c + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // ---------------- per-frame configuration ----------------
    logic [SUM_W-1:0] thr_q, thr_c;
    mode_e            mode_q, mode_c;
    logic             sop_pix_c;

    assign sop_pix_c = din_vld && din_sop;
    assign thr_c     = sop_pix_c ? thr : thr_q;
    assign mode_c    = sop_pix_c ? mode_e'(mode) : mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_q  <= '0;
            mode_q <= MODE_BIN;
        end else begin
            thr_q  <= thr_c;
            mode_q <= mode_c;
        end
    end

    logic bdr_c;
`ifdef SOBEL_BORDER_ZERO_EN
    assign bdr_c = (px_c < X_W'(2)) || (py_c < Y_W'(2));
`else
    assign bdr_c = 1'b0;
`endif

    // ---------------- line buffers ----------------
    logic [DATA_W-1:0] row1_c, row2_c;

    sobel_line_buf #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_line_buf (
        .clk      (clk),
        .wr_en_i  (din_vld),
        .x_i      (px_c),
        .din_i    (din),
        .row1_c_o (row1_c),
        .row2_c_o (row2_c)
    );

    // ---------------- sideband delay line ----------------
    side_t side_q [SOBEL_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SOBEL_LAT); i++) begin
                side_q[i] <= '0;
            end
        end else begin
            side_q[0] <= '{vld: din_vld, sop: din_sop, eop: din_eop};
            for (int i = 1; i < int'(SOBEL_LAT); i++) begin
                side_q[i] <= side_q[i-1];
            end
        end
    end

    // ---------------- stage 1: 3x3 window, row 0 = oldest line ----------------
    logic [DATA_W-1:0] win_q [3][3];
    logic [SUM_W-1:0]  s1_thr_q;
    mode_e             s1_mode_q;
    logic              s1_bdr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            s1_thr_q  <= '0;
            s1_mode_q <= MODE_BIN;
            s1_bdr_q  <= 1'b0;
        end else if (din_vld) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= row2_c;
            win_q[1][2] <= row1_c;
            win_q[2][2] <= din;
            s1_thr_q    <= thr_c;
            s1_mode_q   <= mode_c;
            s1_bdr_q    <= bdr_c;
        end
    end

    // ---------------- stage 2: signed gradients ----------------
    logic [ABS_W-1:0]       left_c, right_c, top_c, bot_c;
    logic signed [G_W-1:0]  gx_c, gy_c, gx_q, gy_q;
    logic [SUM_W-1:0]       s2_thr_q;
    mode_e                  s2_mode_q;
    logic                   s2_bdr_q;

    always_comb begin
        left_c  = ABS_W'(win_q[0][0]) + (ABS_W'(win_q[1][0]) << 1) + ABS_W'(win_q[2][0]);
        right_c = ABS_W'(win_q[0][2]) + (ABS_W'(win_q[1][2]) << 1) + ABS_W'(win_q[2][2]);
        top_c   = ABS_W'(win_q[0][0]) + (ABS_W'(win_q[0][1]) << 1) + ABS_W'(win_q[0][2]);
        bot_c   = ABS_W'(win_q[2][0]) + (ABS_W'(win_q[2][1]) << 1) + ABS_W'(win_q[2][2]);
        gx_c    = $signed({1'b0, right_c}) - $signed({1'b0, left_c});
        gy_c    = $signed({1'b0, top_c}) - $signed({1'b0, bot_c});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_q      <= '0;
            gy_q      <= '0;
            s2_thr_q  <= '0;
            s2_mode_q <= MODE_BIN;
            s2_bdr_q  <= 1'b0;
        end else if (side_q[0].vld) begin
            gx_q      <= gx_c;
            gy_q      <= gy_c;
            s2_thr_q  <= s1_thr_q;
            s2_mode_q <= s1_mode_q;
            s2_bdr_q  <= s1_bdr_q;
        end
    end

    // ---------------- stage 3: |gx| + |gy| ----------------
    logic [ABS_W-1:0] abs_x_c, abs_y_c;
    logic [SUM_W-1:0] sum_c, s3_sum_q, s3_thr_q;
    mode_e            s3_mode_q;
    logic             s3_bdr_q;

    always_comb begin
        abs_x_c = gx_q[G_W-1] ? ABS_W'(-gx_q) : ABS_W'(gx_q);
        abs_y_c = gy_q[G_W-1] ? ABS_W'(-gy_q) : ABS_W'(gy_q);
        sum_c   = SUM_W'(abs_x_c) + SUM_W'(abs_y_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_sum_q  <= '0;
            s3_thr_q  <= '0;
            s3_mode_q <= MODE_BIN;
            s3_bdr_q  <= 1'b0;
        end else if (side_q[1].vld) begin
            s3_sum_q  <= sum_c;
            s3_thr_q  <= s2_thr_q;
            s3_mode_q <= s2_mode_q;
            s3_bdr_q  <= s2_bdr_q;
        end
    end

    // ---------------- stage 4: output select ----------------
    logic [DATA_W-1:0] res_c, dout_q;

    always_comb begin
        res_c = '0;
        if (s3_bdr_q) begin
            res_c = '0;
        end else if (s3_mode_q == MODE_MAG) begin
            res_c = (s3_sum_q > SUM_W'(PIX_MAX)) ? '1 : DATA_W'(s3_sum_q);
        end else begin
            res_c = (s3_sum_q > s3_thr_q) ? '1 : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else if (side_q[2].vld) begin
            dout_q <= res_c;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = side_q[SOBEL_LAT-1].vld;
    assign dout_sop = side_q[SOBEL_LAT-1].sop;
    assign dout_eop = side_q[SOBEL_LAT-1].eop;

endmodule

// File: doc/sobel_gray.md
SOBEL_GRAY -- requirements
Module: sobel_gray

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640: pixels per line, which sets the line-buffer depth.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports din_sop, din_eop and din_vld, each input, 1 bit: frame start, frame end and pixel valid.
REQ-006 SHALL have port din, input, DATA_W bits: grayscale pixel.
REQ-007 SHALL have port thr, input, DATA_W+3 bits: gradient threshold.
REQ-008 SHALL have port mode, input, 1 bit: 0 selects binary output, 1 selects magnitude output.
REQ-009 SHALL have ports dout_sop, dout_eop and dout_vld, each output, 1 bit: delayed sideband signals.
REQ-010 SHALL have port dout, output, DATA_W bits: edge result.

Function
REQ-011 SHALL keep column counter x (0..IMG_W-1) and row counter y.
- Pixel with din_vld=1 and din_sop=1: x=0, y=0.
- Each subsequent valid pixel increments x.
- x wraps IMG_W-1 -> 0, and y increments on that wrap.
REQ-012 SHALL hold two lines of history in line buffers and 3x3 window registers; these SHALL advance only when din_vld=1.
REQ-013 SHALL form the window from rows y-2..y and columns x-2..x; the result belongs to centre (x-1, y-1).
REQ-014 SHALL compute gx = (right column) - (left column) and gy = (top row) - (bottom row).
- Column and row weights are 1,2,1, all signed.
- Widths: |gx| and |gy| are DATA_W+2 bits; sum s = |gx|+|gy| is DATA_W+3 bits.
- No overflow is permitted at any stage.
REQ-015 SHALL select the output by mode:
- mode=0: dout = all-ones when s > thr, else 0 (strictly greater).
- mode=1: dout = min(s, 2^DATA_W-1), i.e. saturated.
REQ-016 SHALL sample thr and mode on the valid sop pixel and hold them constant for the rest of the frame.
REQ-017 SHALL have a fixed latency of 4 clk cycles from din_vld/din_sop/din_eop to dout_vld/dout_sop/dout_eop, independent of gaps in din_vld.
REQ-018 SHALL update dout only in cycles where dout_vld=1; otherwise dout holds its previous value.
REQ-019 SHALL handle a sop arriving mid-frame by resynchronising x and y immediately.
- Line-buffer contents SHALL NOT be cleared.
REQ-020 SHALL treat eop as pass-through only, with no effect on the counters.
REQ-021 SHALL, when din_vld=1 arrives with x=IMG_W-1 and no sop, wrap without error.
REQ-022 SHALL let the sop flag win when sop and the wrap occur on the same pixel.

Reset
REQ-023 SHALL, while rst=1, hold dout, dout_sop, dout_eop, dout_vld, all pipeline valid/sideband registers, x, y, and the sampled thr/mode at 0.
REQ-024 SHALL, after reset mid-frame, produce no dout_vld until new din_vld input has travelled the 4-cycle pipeline.
- Line-buffer RAM need not be cleared.

Configuration
REQ-025 SHALL, with SOBEL_BORDER_ZERO_EN defined, force dout=0 for every output whose input pixel had x<2 or y<2 (the incomplete window).
REQ-026 SHALL, without SOBEL_BORDER_ZERO_EN, output the computed value for those pixels, using stale or reset window contents; this is the legacy behaviour.

Structure
REQ-027 SHALL put the following in shared package sobel_pkg:
- widths derived from DATA_W: abs width DATA_W+2, sum width DATA_W+3;
- the latency constant SOBEL_LAT=4;
- the mode encodings MODE_BIN=0 and MODE_MAG=1.
REQ-028 SHALL use one sub-module, sobel_line_buf.
- Parameters: DATA_W and IMG_W.
- Function: two cascaded single-port-read/write line delays indexed by x, plus write enable = din_vld.
- Outputs: taps for rows y-1 and y-2.

Verification (DATA_W=8, IMG_W=8, 8x8 frames)
REQ-029 SHALL cover a flat frame: all pixels 100, mode=1 -> every dout=0; mode=0 with thr=0 -> every dout=0.
REQ-030 SHALL cover a vertical edge: columns 0-3=0, columns 4-7=255, mode=1 -> interior windows spanning the edge give dout=255 (s=1020 saturated); other interior windows give 0.
REQ-031 SHALL cover the threshold boundary with a window giving s=40, mode=0:
- thr=40 -> dout=0;
- thr=39 -> dout=8'hFF.
REQ-032 SHALL cover gapped input: the same frame with din_vld every other cycle -> an identical dout sequence, each dout_vld exactly 4 cycles after its din_vld, and sop/eop aligned.
REQ-033 SHALL cover the border option: with SOBEL_BORDER_ZERO_EN and the vertical-edge frame, outputs for rows 0-1 and columns 0-1 are 0.
REQ-034 SHALL cover reset mid-frame: rst=1 for 1 cycle at pixel 20 -> all outputs 0 the same cycle; then a new frame gives correct results from its sop.
